// File: rtl/clock_pkg.sv
// Shared time-of-day widths, default wrap values and the packed h:m:s record
// used by the time counter and the calendar/display blocks downstream.
package clock_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam int DEF_HOURS_PER_DAY = 24;
  localparam int DEF_MIN_PER_HOUR  = 60;
  localparam int DEF_SEC_PER_MIN   = 60;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } hms_t;

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous level into the clk domain and flags its rising
// edge as a one-cycle pulse. Also intended for the push-button inputs.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/time_counter.sv
// Time-of-day counter (binary h:m:s) advanced by the synchronized 1 Hz edge,
// with a range-checked load port and a day-rollover pulse for the calendar.
module time_counter
  import clock_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int HOURS_PER_DAY = DEF_HOURS_PER_DAY,
  parameter int SEC_PER_MIN   = DEF_SEC_PER_MIN,
  parameter int MIN_PER_HOUR  = DEF_MIN_PER_HOUR
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,
  input  logic              clk_1Hz,
  input  logic              run,
  input  logic              set_valid,
  input  logic [HOUR_W-1:0] set_hour,
  input  logic [MIN_W-1:0]  set_min,
  input  logic [SEC_W-1:0]  set_sec,
  output logic              set_err,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  min,
  output logic [SEC_W-1:0]  sec,
  output logic              sec_tick,
  output logic              day_pulse
);

  hms_t time_q, time_d;
  logic tick_q, tick_d;
  logic day_q, day_d;
  logic err_q, err_d;
  logic rise;
  logic load_ok;
  logic sec_last, min_last, hour_last;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk_100MHz),
    .rst_n  (reset_n),
    .async_i(clk_1Hz),
    .rise_o (rise)
  );

  assign load_ok   = (32'(set_hour) < 32'(HOURS_PER_DAY)) &&
                     (32'(set_min)  < 32'(MIN_PER_HOUR))  &&
                     (32'(set_sec)  < 32'(SEC_PER_MIN));
  assign sec_last  = (time_q.sec  == SEC_W'(SEC_PER_MIN - 1));
  assign min_last  = (time_q.min  == MIN_W'(MIN_PER_HOUR - 1));
  assign hour_last = (time_q.hour == HOUR_W'(HOURS_PER_DAY - 1));

  // A load request always consumes a coincident tick, accepted or not.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches.
    time_d = time_q;
    tick_d = 1'b0;
    day_d  = 1'b0;
    err_d  = 1'b0;
    if (set_valid) begin
      if (load_ok) begin
        time_d = '{hour: set_hour, min: set_min, sec: set_sec};
      end else begin
        err_d = 1'b1;
      end
    end else if (rise && run) begin
      tick_d = 1'b1;
      if (!sec_last) begin
        time_d.sec = time_q.sec + SEC_W'(1);
      end else begin
        time_d.sec = '0;
        if (!min_last) begin
          time_d.min = time_q.min + MIN_W'(1);
        end else begin
          time_d.min = '0;
          if (!hour_last) begin
            time_d.hour = time_q.hour + HOUR_W'(1);
          end else begin
            time_d.hour = '0;
            day_d       = 1'b1;
          end
        end
      end
    end
  end

  // NOTE: the async reset clears every flop, pulses included, so a reset
  // mid-operation drops any tick or load already in flight.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      time_q <= '0;
      tick_q <= 1'b0;
      day_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      time_q <= time_d;
      tick_q <= tick_d;
      day_q  <= day_d;
      err_q  <= err_d;
    end
  end

  assign hour      = time_q.hour;
  assign min       = time_q.min;
  assign sec       = time_q.sec;
  assign sec_tick  = tick_q;
  assign day_pulse = day_q;
  assign set_err   = err_q;

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter: reference model keeps time as seconds
// of the day; table vectors, hand-written corner sequences and random ops.
module tb_time_counter;
  import clock_pkg::*;

  localparam int DAY = 24 * 60 * 60;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              clk_1Hz = 1'b0;
  logic              run = 1'b0;
  logic              set_valid = 1'b0;
  logic [HOUR_W-1:0] set_hour = '0;
  logic [MIN_W-1:0]  set_min = '0;
  logic [SEC_W-1:0]  set_sec = '0;
  logic              set_err;
  logic [HOUR_W-1:0] hour;
  logic [MIN_W-1:0]  min;
  logic [SEC_W-1:0]  sec;
  logic              sec_tick;
  logic              day_pulse;

  int total = 0;
  int bad = 0;
  int model_tod = 0;

  typedef struct {
    int h, m, s;
    int edges;
    int exp_h, exp_m, exp_s;
    int exp_err;
  } vec_t;

  vec_t vecs[8];

  time_counter dut (
    .clk_100MHz(clk),
    .reset_n   (reset_n),
    .clk_1Hz   (clk_1Hz),
    .run       (run),
    .set_valid (set_valid),
    .set_hour  (set_hour),
    .set_min   (set_min),
    .set_sec   (set_sec),
    .set_err   (set_err),
    .hour      (hour),
    .min       (min),
    .sec       (sec),
    .sec_tick  (sec_tick),
    .day_pulse (day_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic check_time(input string name);
    check({name, ".hour"}, int'(hour), model_tod / 3600);
    check({name, ".min"},  int'(min),  (model_tod / 60) % 60);
    check({name, ".sec"},  int'(sec),  model_tod % 60);
  endtask

  // One full clk_1Hz period: rise, observe, fall, observe.
  task automatic do_edge(input bit run_v, output int ticks, output int days,
                         output int first_at);
    ticks = 0; days = 0; first_at = -1;
    @(negedge clk);
    run = run_v;
    clk_1Hz = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (sec_tick) begin
        ticks++;
        if (first_at < 0) first_at = k;
      end
      if (day_pulse) days += sec_tick ? 1 : 100;
    end
    clk_1Hz = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (sec_tick) ticks++;
      if (day_pulse) days++;
    end
  endtask

  task automatic edge_check(input string name, input bit run_v);
    int ticks, days, first_at, exp_day;
    exp_day = (run_v && model_tod == DAY - 1) ? 1 : 0;
    do_edge(run_v, ticks, days, first_at);
    if (run_v) model_tod = (model_tod + 1) % DAY;
    check({name, ".ticks"}, ticks, run_v ? 1 : 0);
    check({name, ".day"}, days, exp_day);
    if (run_v) check({name, ".latency"}, first_at, 3);
    check_time(name);
  endtask

  task automatic load_check(input string name, input int h, input int m, input int s);
    bit valid;
    int err1, tick1, err2;
    valid = (h < 24) && (m < 60) && (s < 60);
    @(negedge clk);
    set_valid = 1'b1;
    set_hour = HOUR_W'(h); set_min = MIN_W'(m); set_sec = SEC_W'(s);
    @(negedge clk);
    set_valid = 1'b0;
    err1 = int'(set_err); tick1 = int'(sec_tick);
    @(negedge clk);
    err2 = int'(set_err);
    if (valid) model_tod = h * 3600 + m * 60 + s;
    check({name, ".err"}, err1, valid ? 0 : 1);
    check({name, ".tick"}, tick1, 0);
    check({name, ".err_len"}, err2, 0);
    check_time(name);
  endtask

  // Load presented exactly in the cycle where the synchronized rise is live.
  task automatic collide(input string name, input int h, input int m, input int s);
    bit valid;
    int ticks, errs;
    valid = (h < 24) && (m < 60) && (s < 60);
    ticks = 0; errs = 0;
    @(negedge clk);
    run = 1'b1;
    clk_1Hz = 1'b1;
    @(negedge clk);
    @(negedge clk);
    set_valid = 1'b1;
    set_hour = HOUR_W'(h); set_min = MIN_W'(m); set_sec = SEC_W'(s);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      set_valid = 1'b0;
      if (sec_tick) ticks++;
      if (set_err) errs++;
    end
    clk_1Hz = 1'b0;
    repeat (4) @(negedge clk);
    if (valid) model_tod = h * 3600 + m * 60 + s;
    check({name, ".ticks"}, ticks, 0);
    check({name, ".errs"}, errs, valid ? 0 : 1);
    check_time(name);
  endtask

  initial begin
    int ticks, first_at;

    vecs[0] = '{23, 59, 58, 2,  0,  0,  0, 0};
    vecs[1] = '{10, 59, 59, 1, 11,  0,  0, 0};
    vecs[2] = '{ 0,  0, 59, 1,  0,  1,  0, 0};
    vecs[3] = '{24,  0,  0, 0,  0,  1,  0, 1};
    vecs[4] = '{12, 60,  0, 0,  0,  1,  0, 1};
    vecs[5] = '{12, 34, 60, 0,  0,  1,  0, 1};
    vecs[6] = '{23, 59, 59, 1,  0,  0,  0, 0};
    vecs[7] = '{ 0,  0,  0, 1,  0,  0,  1, 0};

    // Reset state, with clk_1Hz already high when reset releases.
    clk_1Hz = 1'b1;
    run = 1'b1;
    #2;
    check_time("reset");
    check("reset.tick", int'(sec_tick), 0);
    check("reset.day", int'(day_pulse), 0);
    check("reset.err", int'(set_err), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    ticks = 0; first_at = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (sec_tick) begin
        ticks++;
        if (first_at < 0) first_at = k;
      end
    end
    model_tod = 1;
    check("high_at_release.ticks", ticks, 1);
    check("high_at_release.latency", first_at, 3);
    check_time("high_at_release");
    clk_1Hz = 1'b0;
    repeat (4) @(negedge clk);

    edge_check("first_edge", 1'b1);

    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      load_check(nm, vecs[i].h, vecs[i].m, vecs[i].s);
      check({nm, ".exp_err"}, vecs[i].exp_err, ((vecs[i].h < 24) && (vecs[i].m < 60) && (vecs[i].s < 60)) ? 0 : 1);
      for (int e = 0; e < vecs[i].edges; e++) edge_check(nm, 1'b1);
      check({nm, ".final_h"}, int'(hour), vecs[i].exp_h);
      check({nm, ".final_m"}, int'(min),  vecs[i].exp_m);
      check({nm, ".final_s"}, int'(sec),  vecs[i].exp_s);
    end

    collide("collide_ok", 5, 6, 7);
    edge_check("after_collide", 1'b1);
    collide("collide_bad", 30, 0, 0);

    for (int i = 0; i < 3; i++) edge_check("frozen", 1'b0);
    load_check("frozen_load", 7, 8, 9);

    // Asynchronous reset while a tick is working through the synchronizer.
    load_check("pre_reset", 12, 34, 56);
    @(negedge clk);
    clk_1Hz = 1'b1;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    model_tod = 0;
    check_time("async_reset");
    check("async_reset.tick", int'(sec_tick), 0);
    clk_1Hz = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    ticks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (sec_tick) ticks++;
    end
    check("cancelled_tick", ticks, 0);
    edge_check("resume", 1'b1);

    for (int i = 0; i < 300; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 1)
        load_check("rnd_load", int'($urandom_range(0, 26)), int'($urandom_range(0, 62)),
                   int'($urandom_range(0, 62)));
      else if (op == 2)
        load_check("rnd_near_end", 23, 59, int'($urandom_range(55, 59)));
      else
        edge_check("rnd_edge", $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_counter.md
Name: time_counter

Overview:
- Consumes the 1 Hz square wave from the 1 Hz timer and keeps time of day as hours, minutes and seconds, all in binary.
- Runs entirely on the 100 MHz system clock. The 1 Hz input is synchronized, and its rising edge becomes a one-cycle second tick.
- Provides a validated load port so the set/button logic can set the time.
- Emits a one-cycle day-rollover pulse to drive the downstream calendar stage.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops on clk_1Hz. Legal values are 2 or more.
- HOURS_PER_DAY, 24: the hour counter wraps at this value, so hours run 0 to HOURS_PER_DAY-1. Legal range 1 to 32.
- SEC_PER_MIN, 60: seconds wrap value. Reduced only to shorten simulation.
- MIN_PER_HOUR, 60: minutes wrap value.

Ports:
- clk_100MHz  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- clk_1Hz  in  1  1 Hz square wave from the timer stage. Treated as asynchronous.
- run  in  1  1 = seconds tick advances time; 0 = time frozen. Ticks are dropped, not queued.
- set_valid  in  1  one-cycle load request.
- set_hour  in  5  requested hour.
- set_min  in  6  requested minute.
- set_sec  in  6  requested second.
- set_err  out  1  one-cycle pulse: the load was rejected for an out-of-range value.
- hour  out  5  current hour.
- min  out  6  current minute.
- sec  out  6  current second.
- sec_tick  out  1  one-cycle pulse on each accepted second advance.
- day_pulse  out  1  one-cycle pulse when time wraps from the last second of the day to 00:00:00.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - hour, min, sec = 0.
  - sec_tick, day_pulse, set_err = 0.
  - Synchronizer and edge-history flops cleared to 0. A clk_1Hz already high at reset release therefore produces one tick SYNC_STAGES+1 cycles later.
  - Reset asserted mid-operation cancels any in-flight tick or load.
- Edge detection:
  - clk_1Hz passes through SYNC_STAGES flops, then one history flop.
  - rise = last sync stage 1 AND history 0.
  - Outputs update on the clock edge where rise is 1. That is SYNC_STAGES+1 clk_100MHz edges after clk_1Hz rises, given setup is met; this is 3 cycles with the default.
  - Exactly one rise per clk_1Hz period. Falling edges are ignored.
- Advance, applied when rise=1, run=1 and set_valid=0:
  - sec increments.
  - If sec = SEC_PER_MIN-1: sec→0 and min increments.
  - If min also = MIN_PER_HOUR-1: min→0 and hour increments.
  - If hour also = HOURS_PER_DAY-1: hour→0.
  - sec_tick=1 in the same cycle as the registered update, i.e. the cycle after the edge where the new value appears.
  - day_pulse=1 alongside sec_tick only when the full wrap to 00:00:00 occurs.
- Load, applied when set_valid=1:
  - Valid load (set_hour<HOURS_PER_DAY, set_min<MIN_PER_HOUR, set_sec<SEC_PER_MIN): values are registered at the next edge. No sec_tick, no day_pulse.
  - Invalid load: time unchanged; set_err pulses for 1 cycle, registered.
  - Load works whether run is 0 or 1.
- Simultaneous set_valid and rise:
  - The load wins and the tick is discarded. No sec_tick.
  - This holds even if the load is rejected, so no double update is possible.
- rise with run=0: no change and no pulses. The tick is lost.
- All outputs are registered. No combinational path from inputs to outputs.
- There is no state machine beyond the counter chain. The implicit counter state is 24*60*60 = 86400 states.

Decomposition:
- Package clock_pkg holds:
  - Width constants HOUR_W=5, MIN_W=6, SEC_W=6.
  - Default wrap constants 24, 60, 60.
  - These are shared with the future calendar and display blocks.
- Sub-module edge_sync, parameterized by SYNC_STAGES:
  - Asynchronous active-low reset synchronizer chain plus rising-edge detector.
  - Output: the one-cycle rise.
  - Reusable for the button inputs.

Test Plan:
- Reset release, then clk_1Hz rising at t0 (run=1) → sec 0→1 appears 3 cycles after t0, sec_tick high for exactly 1 cycle. The falling edge produces nothing.
- Load 23:59:58, then 2 rising edges → 23:59:59, then 00:00:00. day_pulse=1 only in the second sec_tick cycle.
- Load 10:59:59, then 1 edge → 11:00:00, day_pulse=0. Load 00:00:59 → 00:01:00.
- set_valid with 24:00:00, then with 12:60:00 → set_err pulses once per request, time unchanged, no sec_tick.
- set_valid=1 with 05:06:07 in the same cycle as rise → time = 05:06:07, no sec_tick. Next edge → 05:06:08.
- run=0 across 3 edges → time frozen, no pulses. reset_n low mid-count (asynchronously, between clock edges) → outputs are 0 immediately. Resume after release → counting starts from 00:00:00.
